// File: rtl/drop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drop_sequencer_pkg
// Description : Shared types and constants for the baggage-drop sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package drop_sequencer_pkg;

    localparam int c_SENSOR_W = 8;

    typedef logic [c_SENSOR_W-1:0] sensor_t;
    typedef logic [1:0]            status_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LATCH  = 3'd2,
        S_DECIDE = 3'd3,
        S_DROP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam status_t ST_ABORT   = 2'b00;
    localparam status_t ST_DROP    = 2'b01;
    localparam status_t ST_REJECT  = 2'b10;
    localparam status_t ST_TIMEOUT = 2'b11;

endpackage : drop_sequencer_pkg
`default_nettype wire

// File: rtl/drop_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : drop_sequencer_if
// Description : Control, sensor and result signals of the drop sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface drop_sequencer_if;
    import drop_sequencer_pkg::*;

    logic    start;
    logic    abort;
    sensor_t sensor1;
    sensor_t sensor2;
    sensor_t sensor3;
    sensor_t sensor4;
    sensor_t max_height;
    logic    busy;
    sensor_t height;
    logic    height_valid;
    logic    drop_active;
    logic    done;
    status_t status;

    modport master (
        output start, abort, sensor1, sensor2, sensor3, sensor4, max_height,
        input  busy, height, height_valid, drop_active, done, status
    );

    modport slave (
        input  start, abort, sensor1, sensor2, sensor3, sensor4, max_height,
        output busy, height, height_valid, drop_active, done, status
    );

endinterface : drop_sequencer_if
`default_nettype wire

// File: rtl/drop_sequencer_sensors_input.sv
`default_nettype none
// ============================================================================
// Module      : sensors_input
// Description : Combinational bag-height estimator; faulty (zero) sensors
//               drop their diagonal pair out of the average.
// Revision    : 1.0 - initial release
// ============================================================================
module sensors_input
    import drop_sequencer_pkg::*;
(
    input  sensor_t i_sensor1,
    input  sensor_t i_sensor2,
    input  sensor_t i_sensor3,
    input  sensor_t i_sensor4,
    output sensor_t o_height
);

    logic [9:0] w_sum_24;
    logic [9:0] w_sum_13;
    logic [9:0] w_sum_all;
    logic [9:0] w_avg_24;
    logic [9:0] w_avg_13;
    logic [9:0] w_avg_all;

    always_comb begin
        w_sum_24  = {2'b00, i_sensor2} + {2'b00, i_sensor4} + 10'd1;
        w_sum_13  = {2'b00, i_sensor1} + {2'b00, i_sensor3} + 10'd1;
        w_sum_all = {2'b00, i_sensor1} + {2'b00, i_sensor2}
                  + {2'b00, i_sensor3} + {2'b00, i_sensor4} + 10'd2;
        w_avg_24  = w_sum_24  >> 1;
        w_avg_13  = w_sum_13  >> 1;
        w_avg_all = w_sum_all >> 2;

        // Later rules override earlier ones; the all-nonzero case is the
        // fall-through, so it is written as the default.
        o_height = w_avg_all[7:0];
        if ((i_sensor1 == '0) || (i_sensor3 == '0)) begin
            o_height = w_avg_24[7:0];
        end
        if ((i_sensor2 == '0) || (i_sensor4 == '0)) begin
            o_height = w_avg_13[7:0];
        end
    end

endmodule : sensors_input
`default_nettype wire

// File: rtl/drop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : drop_sequencer
// Description : One baggage-drop measurement per start: settle, latch height,
//               compare against limit, pulse the drop actuator.
// Revision    : 1.0 - initial release
// ============================================================================
module drop_sequencer
    import drop_sequencer_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DROP_CYCLES    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    drop_sequencer_if.slave    bus
);

    localparam int c_STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int c_TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_DROP_W = (DROP_CYCLES > 2) ? $clog2(DROP_CYCLES) : 1;

    localparam logic [c_STAB_W-1:0] c_STAB_DONE = c_STAB_W'(STABLE_CYCLES);
    localparam logic [c_STAB_W-1:0] c_STAB_ONE  = c_STAB_W'(1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_ONE   = c_TMO_W'(1);
    localparam logic [c_DROP_W-1:0] c_DROP_LAST = c_DROP_W'(DROP_CYCLES - 1);
    localparam logic [c_DROP_W-1:0] c_DROP_ONE  = c_DROP_W'(1);

    state_t               r_state,        w_state;
    sensor_t              r_max_q,        w_max_q;
    sensor_t              r_snap1,        w_snap1;
    sensor_t              r_snap2,        w_snap2;
    sensor_t              r_snap3,        w_snap3;
    sensor_t              r_snap4,        w_snap4;
    logic [c_STAB_W-1:0]  r_stab_cnt,     w_stab_cnt;
    logic [c_TMO_W-1:0]   r_tmo_cnt,      w_tmo_cnt;
    logic [c_DROP_W-1:0]  r_drop_cnt,     w_drop_cnt;
    sensor_t              r_height,       w_height;
    logic                 r_height_valid, w_height_valid;
    logic                 r_drop_active,  w_drop_active;
    status_t              r_status,       w_status;

    sensor_t              w_estimate;
    logic                 w_sens_stable;

    sensors_input u_sensors_input (
        .i_sensor1 (r_snap1),
        .i_sensor2 (r_snap2),
        .i_sensor3 (r_snap3),
        .i_sensor4 (r_snap4),
        .o_height  (w_estimate)
    );

    assign w_sens_stable = (bus.sensor1 == r_snap1) && (bus.sensor2 == r_snap2) &&
                           (bus.sensor3 == r_snap3) && (bus.sensor4 == r_snap4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_max_q        <= '0;
            r_snap1        <= '0;
            r_snap2        <= '0;
            r_snap3        <= '0;
            r_snap4        <= '0;
            r_stab_cnt     <= '0;
            r_tmo_cnt      <= '0;
            r_drop_cnt     <= '0;
            r_height       <= '0;
            r_height_valid <= 1'b0;
            r_drop_active  <= 1'b0;
            r_status       <= ST_ABORT;
        end else begin
            r_state        <= w_state;
            r_max_q        <= w_max_q;
            r_snap1        <= w_snap1;
            r_snap2        <= w_snap2;
            r_snap3        <= w_snap3;
            r_snap4        <= w_snap4;
            r_stab_cnt     <= w_stab_cnt;
            r_tmo_cnt      <= w_tmo_cnt;
            r_drop_cnt     <= w_drop_cnt;
            r_height       <= w_height;
            r_height_valid <= w_height_valid;
            r_drop_active  <= w_drop_active;
            r_status       <= w_status;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_max_q        = r_max_q;
        w_snap1        = r_snap1;
        w_snap2        = r_snap2;
        w_snap3        = r_snap3;
        w_snap4        = r_snap4;
        w_stab_cnt     = r_stab_cnt;
        w_tmo_cnt      = r_tmo_cnt;
        w_drop_cnt     = r_drop_cnt;
        w_height       = r_height;
        w_height_valid = r_height_valid;
        w_drop_active  = r_drop_active;
        w_status       = r_status;

        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state        = S_SETTLE;
                    w_max_q        = bus.max_height;
                    w_height       = '0;
                    w_height_valid = 1'b0;
                    w_status       = ST_ABORT;
                    w_snap1        = bus.sensor1;
                    w_snap2        = bus.sensor2;
                    w_snap3        = bus.sensor3;
                    w_snap4        = bus.sensor4;
                    w_stab_cnt     = c_STAB_ONE;
                    w_tmo_cnt      = '0;
                end
            end

            S_SETTLE: begin
                if (bus.abort) begin
                    w_state  = S_DONE;
                    w_status = ST_ABORT;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + c_TMO_ONE;
                    if (w_sens_stable) begin
                        w_stab_cnt = r_stab_cnt + c_STAB_ONE;
                    end else begin
                        w_snap1    = bus.sensor1;
                        w_snap2    = bus.sensor2;
                        w_snap3    = bus.sensor3;
                        w_snap4    = bus.sensor4;
                        w_stab_cnt = c_STAB_ONE;
                    end
                    // Stability is checked first so it wins a same-cycle timeout.
                    if (w_stab_cnt == c_STAB_DONE) begin
                        w_state = S_LATCH;
                    end else if (w_tmo_cnt == c_TMO_LAST) begin
                        w_state  = S_DONE;
                        w_status = ST_TIMEOUT;
                    end
                end
            end

            S_LATCH: begin
                if (bus.abort) begin
                    w_state  = S_DONE;
                    w_status = ST_ABORT;
                end else begin
                    w_height       = w_estimate;
                    w_height_valid = 1'b1;
                    w_state        = S_DECIDE;
                end
            end

            S_DECIDE: begin
                if (bus.abort) begin
                    w_state  = S_DONE;
                    w_status = ST_ABORT;
                end else if ((r_height != '0) && (r_height <= r_max_q)) begin
                    w_state       = S_DROP;
                    w_drop_active = 1'b1;
                    w_drop_cnt    = '0;
                end else begin
                    w_state  = S_DONE;
                    w_status = ST_REJECT;
                end
            end

            S_DROP: begin
                if (bus.abort) begin
                    w_state       = S_DONE;
                    w_status      = ST_ABORT;
                    w_drop_active = 1'b0;
                end else if (r_drop_cnt == c_DROP_LAST) begin
                    w_state       = S_DONE;
                    w_status      = ST_DROP;
                    w_drop_active = 1'b0;
                end else begin
                    w_drop_cnt = r_drop_cnt + c_DROP_ONE;
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state       = S_IDLE;
                w_drop_active = 1'b0;
            end
        endcase
    end

    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = (r_state == S_DONE);
    assign bus.height       = r_height;
    assign bus.height_valid = r_height_valid;
    assign bus.drop_active  = r_drop_active;
    assign bus.status       = r_status;

endmodule : drop_sequencer
`default_nettype wire
